// File: rtl/acc_core.sv
`default_nettype none
// ============================================================================
//  Module   : acc_core
//  Purpose  : Multi-cycle accumulator CPU core with integrated control FSM.
//             Harvard organisation: combinational instruction port and a
//             valid/ack handshaked data port. Persistent {N,Z,C,V} flags,
//             conditional branches (JZ/JN/JC) and a HALT state that only
//             reset can leave.
//  Optional : define ACC_CORE_ADC_EN to turn opcode E into ADC
//             (AC <= AC + B + C); otherwise opcode E is a NOP.
//  Ports    :
//    clk         in   rising-edge clock
//    reset       in   synchronous, active-low reset
//    imem_addr   out  AW      instruction address (= PC)
//    imem_rdata  in   4+AW    instruction {opcode[3:0], addr[AW-1:0]}
//    dmem_req    out  1       data access request (high in MEM)
//    dmem_we     out  1       1 = write, 0 = read (qualified by dmem_req)
//    dmem_addr   out  AW      data address (IR address field)
//    dmem_wdata  out  DW      AC value for writes
//    dmem_rdata  in   DW      read data, sampled on the ack cycle
//    dmem_ack    in   1       access complete
//    out_data    out  DW      O register
//    out_valid   out  1       one-cycle pulse when O is written
//    flags       out  4       registered {N,Z,C,V}
//    halted      out  1       core stopped in HALT
//    state       out  3       current FSM state (debug)
//  Revision : 1.0 - initial parametrised release
// ============================================================================
module acc_core #(
  parameter int DW = 8,
  parameter int AW = 8
) (
  input  logic          clk,
  input  logic          reset,
  output logic [AW-1:0] imem_addr,
  input  logic [AW+3:0] imem_rdata,
  output logic          dmem_req,
  output logic          dmem_we,
  output logic [AW-1:0] dmem_addr,
  output logic [DW-1:0] dmem_wdata,
  input  logic [DW-1:0] dmem_rdata,
  input  logic          dmem_ack,
  output logic [DW-1:0] out_data,
  output logic          out_valid,
  output logic [3:0]    flags,
  output logic          halted,
  output logic [2:0]    state
);

  localparam int IW = 4 + AW;

  localparam logic [3:0] c_op_nop = 4'h0;
  localparam logic [3:0] c_op_lda = 4'h1;
  localparam logic [3:0] c_op_sta = 4'h2;
  localparam logic [3:0] c_op_add = 4'h3;
  localparam logic [3:0] c_op_sub = 4'h4;
  localparam logic [3:0] c_op_and = 4'h5;
  localparam logic [3:0] c_op_or  = 4'h6;
  localparam logic [3:0] c_op_xor = 4'h7;
  localparam logic [3:0] c_op_not = 4'h8;
  localparam logic [3:0] c_op_out = 4'h9;
  localparam logic [3:0] c_op_jmp = 4'hA;
  localparam logic [3:0] c_op_jz  = 4'hB;
  localparam logic [3:0] c_op_jn  = 4'hC;
  localparam logic [3:0] c_op_jc  = 4'hD;
`ifdef ACC_CORE_ADC_EN
  localparam logic [3:0] c_op_adc = 4'hE;
`endif
  localparam logic [3:0] c_op_hlt = 4'hF;

  // Flag bit positions inside the {N,Z,C,V} register.
  localparam int c_fn = 3;
  localparam int c_fz = 2;
  localparam int c_fc = 1;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_MEM    = 3'd2,
    S_EXEC   = 3'd3,
    S_HALT   = 3'd4
  } state_t;

  state_t r_state;
  state_t w_state_next;

  logic [AW-1:0] r_pc;
  logic [IW-1:0] r_ir;
  logic [DW-1:0] r_ac;
  logic [DW-1:0] r_b;
  logic [DW-1:0] r_o;
  logic [3:0]    r_flags;
  logic          r_out_valid;

  logic [3:0]    w_op;
  logic [AW-1:0] w_addr;

  assign w_op   = r_ir[IW-1 -: 4];
  assign w_addr = r_ir[AW-1:0];

  // --------------------------------------------------------------------------
  // ALU. ADD, SUB and ADC share one adder: SUB is AC + ~B + 1, so the adder
  // carry-out is directly the no-borrow flag and the same overflow rule holds.
  // --------------------------------------------------------------------------
  logic [DW-1:0] w_b_op;
  logic          w_cin;
  logic          w_logic_op;
  logic [DW-1:0] w_logic_res;
  logic [DW:0]   w_sum;
  logic [DW-1:0] w_alu_res;
  logic          w_alu_c;
  logic          w_alu_v;
  logic [DW-1:0] w_not;

  always_comb begin
    w_b_op      = r_b;
    w_cin       = 1'b0;
    w_logic_op  = 1'b0;
    w_logic_res = '0;
    case (w_op)
      c_op_sub: begin
        w_b_op = ~r_b;
        w_cin  = 1'b1;
      end
`ifdef ACC_CORE_ADC_EN
      c_op_adc: w_cin = r_flags[c_fc];
`endif
      c_op_and: begin
        w_logic_op  = 1'b1;
        w_logic_res = r_ac & r_b;
      end
      c_op_or: begin
        w_logic_op  = 1'b1;
        w_logic_res = r_ac | r_b;
      end
      c_op_xor: begin
        w_logic_op  = 1'b1;
        w_logic_res = r_ac ^ r_b;
      end
      default: ;
    endcase
  end

  assign w_sum     = {1'b0, r_ac} + {1'b0, w_b_op} + {{DW{1'b0}}, w_cin};
  assign w_alu_res = w_logic_op ? w_logic_res : w_sum[DW-1:0];
  assign w_alu_c   = w_logic_op ? 1'b0 : w_sum[DW];
  // Signed overflow: both adder operands share a sign that the result lacks.
  assign w_alu_v   = w_logic_op ? 1'b0 :
                     ((r_ac[DW-1] == w_b_op[DW-1]) && (w_sum[DW-1] != r_ac[DW-1]));
  assign w_not     = ~r_ac;

  // --------------------------------------------------------------------------
  // Control FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset) r_state <= S_FETCH;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_FETCH:  w_state_next = S_DECODE;
      S_DECODE: begin
        case (w_op)
          c_op_lda, c_op_sta, c_op_add, c_op_sub,
          c_op_and, c_op_or,  c_op_xor: w_state_next = S_MEM;
`ifdef ACC_CORE_ADC_EN
          c_op_adc:                     w_state_next = S_MEM;
`endif
          c_op_hlt:                     w_state_next = S_HALT;
          default:                      w_state_next = S_FETCH;
        endcase
      end
      S_MEM: begin
        if (dmem_ack) begin
          if ((w_op == c_op_lda) || (w_op == c_op_sta)) w_state_next = S_FETCH;
          else                                          w_state_next = S_EXEC;
        end
      end
      S_EXEC:   w_state_next = S_FETCH;
      S_HALT:   w_state_next = S_HALT;
      default:  w_state_next = S_FETCH;
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_pc        <= '0;
      r_ir        <= '0;
      r_ac        <= '0;
      r_b         <= '0;
      r_o         <= '0;
      r_flags     <= '0;
      r_out_valid <= 1'b0;
    end else begin
      r_out_valid <= 1'b0;
      case (r_state)
        S_FETCH: begin
          r_ir <= imem_rdata;
          r_pc <= r_pc + AW'(1);
        end
        S_DECODE: begin
          case (w_op)
            c_op_not: begin
              r_ac    <= w_not;
              r_flags <= {w_not[DW-1], ~|w_not, 2'b00};
            end
            c_op_out: begin
              r_o         <= r_ac;
              r_out_valid <= 1'b1;
            end
            c_op_jmp: r_pc <= w_addr;
            c_op_jz:  if (r_flags[c_fz]) r_pc <= w_addr;
            c_op_jn:  if (r_flags[c_fn]) r_pc <= w_addr;
            c_op_jc:  if (r_flags[c_fc]) r_pc <= w_addr;
            default: ;
          endcase
        end
        S_MEM: begin
          if (dmem_ack) begin
            if (w_op == c_op_lda) begin
              // Loads touch only N and Z; C and V keep their last ALU value.
              r_ac          <= dmem_rdata;
              r_flags[c_fn] <= dmem_rdata[DW-1];
              r_flags[c_fz] <= ~|dmem_rdata;
            end else if (w_op != c_op_sta) begin
              r_b <= dmem_rdata;
            end
          end
        end
        S_EXEC: begin
          r_ac    <= w_alu_res;
          r_flags <= {w_alu_res[DW-1], ~|w_alu_res, w_alu_c, w_alu_v};
        end
        default: ;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Outputs (all decoded from registers, so stable through a MEM wait)
  // --------------------------------------------------------------------------
  assign imem_addr  = r_pc;
  assign dmem_req   = (r_state == S_MEM);
  assign dmem_we    = (r_state == S_MEM) && (w_op == c_op_sta);
  assign dmem_addr  = w_addr;
  assign dmem_wdata = r_ac;
  assign out_data   = r_o;
  assign out_valid  = r_out_valid;
  assign flags      = r_flags;
  assign halted     = (r_state == S_HALT);
  assign state      = r_state;

endmodule
`default_nettype wire

// File: tb/tb_acc_core.sv
`default_nettype none
// ============================================================================
//  Module   : tb_acc_core
//  Purpose  : Directed self-checking bench for acc_core (DW=8, AW=8).
//             Combinational ROM model plus a data RAM responder whose ack
//             latency is programmable; expected values are hand-computed.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_acc_core;

  logic        clk;
  logic        reset;
  logic [7:0]  imem_addr;
  logic [11:0] imem_rdata;
  logic        dmem_req;
  logic        dmem_we;
  logic [7:0]  dmem_addr;
  logic [7:0]  dmem_wdata;
  logic [7:0]  dmem_rdata;
  logic        dmem_ack;
  logic [7:0]  out_data;
  logic        out_valid;
  logic [3:0]  flags;
  logic        halted;
  logic [2:0]  state;

`ifdef ACC_CORE_ADC_EN
  localparam bit ADC_EN = 1'b1;
`else
  localparam bit ADC_EN = 1'b0;
`endif

  acc_core #(.DW(8), .AW(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .imem_addr  (imem_addr),
    .imem_rdata (imem_rdata),
    .dmem_req   (dmem_req),
    .dmem_we    (dmem_we),
    .dmem_addr  (dmem_addr),
    .dmem_wdata (dmem_wdata),
    .dmem_rdata (dmem_rdata),
    .dmem_ack   (dmem_ack),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .flags      (flags),
    .halted     (halted),
    .state      (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memories and responder
  logic [11:0] imem [256];
  logic [7:0]  dmem [256];
  int          ack_delay;
  int          wait_cnt;
  logic        ack_force;

  assign imem_rdata = imem[imem_addr];
  assign dmem_rdata = dmem[dmem_addr];

  always_comb dmem_ack = ack_force | (dmem_req === 1'b1 && wait_cnt == ack_delay);

  always @(posedge clk) begin
    if (dmem_req === 1'b1 && dmem_we === 1'b1 && dmem_ack === 1'b1)
      dmem[dmem_addr] = dmem_wdata;
    if (dmem_req !== 1'b1 || dmem_ack === 1'b1) wait_cnt <= 0;
    else                                       wait_cnt <= wait_cnt + 1;
  end

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  function automatic logic [11:0] ins(input logic [3:0] op, input logic [7:0] a);
    return {op, a};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_fetch(input logic [7:0] pc, input string tag);
    int k = 0;
    while (!(state === 3'd0 && imem_addr === pc) && k < 200) begin
      step(1);
      k++;
    end
    check(tag, {state, imem_addr}, {3'd0, pc});
  endtask

  task automatic wait_mem(input logic [7:0] a, input string tag);
    int k = 0;
    while (!(dmem_req === 1'b1 && dmem_addr === a) && k < 200) begin
      step(1);
      k++;
    end
    check(tag, {dmem_req, dmem_addr}, {1'b1, a});
  endtask

  task automatic wait_out(input string tag);
    int k = 0;
    while (out_valid !== 1'b1 && k < 200) begin
      step(1);
      k++;
    end
    check(tag, 32'(out_valid), 32'd1);
  endtask

  initial begin
    logic any_req;
    reset     = 1'b0;
    ack_delay = 0;
    ack_force = 1'b0;
    wait_cnt  = 0;
    for (int i = 0; i < 256; i++) begin
      imem[i] = 12'h000;
      dmem[i] = 8'h00;
    end
    // Program A
    imem[8'h00] = ins(4'h1, 8'h10);  // LDA 10
    imem[8'h01] = ins(4'h3, 8'h11);  // ADD 11
    imem[8'h02] = ins(4'h9, 8'h00);  // OUT
    imem[8'h03] = ins(4'h1, 8'h20);  // LDA 20
    imem[8'h04] = ins(4'h4, 8'h21);  // SUB 21
    imem[8'h05] = ins(4'hC, 8'h40);  // JN 40
    imem[8'h06] = ins(4'hB, 8'h30);  // JZ 30
    imem[8'h30] = ins(4'h1, 8'h22);  // LDA 22
    imem[8'h31] = ins(4'h2, 8'h50);  // STA 50
    imem[8'h32] = ins(4'h1, 8'h51);  // LDA 51
    dmem[8'h10] = 8'h7F;
    dmem[8'h11] = 8'h01;
    dmem[8'h20] = 8'h05;
    dmem[8'h21] = 8'h05;
    dmem[8'h22] = 8'hA5;
    dmem[8'h51] = 8'h3C;

    // Reset state
    step(3);
    check("reset_outputs",
          {state, imem_addr, dmem_req, out_data, out_valid, flags, halted},
          32'd0);
    reset = 1'b1;
    step(1);
    check("first_fetch", {state, imem_addr}, {3'd1, 8'h01});
    step(2);
    check("lda_latency3", {state, imem_addr}, {3'd0, 8'h01});

    // 7F + 01 = 80 : N=1 Z=0 C=0 V=1
    wait_out("out_pulse_a");
    check("out_add", {out_data, flags}, {8'h80, 4'b1001});
    step(1);
    check("out_one_cycle", 32'(out_valid), 32'd0);

    // 05 - 05 = 0 : Z=1 C=1; JN not taken, JZ taken
    wait_fetch(8'h06, "jn_not_taken");
    check("sub_flags", 32'(flags), 32'b0110);
    step(2);
    check("jz_taken", {state, imem_addr}, {3'd0, 8'h30});

    // STA with three wait cycles
    ack_delay = 3;
    wait_mem(8'h50, "sta_req");
    for (int i = 0; i < 4; i++) begin
      check("sta_stable", {dmem_req, dmem_we, dmem_addr, dmem_wdata},
            {1'b1, 1'b1, 8'h50, 8'hA5});
      step(1);
    end
    check("sta_to_fetch", {state, imem_addr, dmem_req}, {3'd0, 8'h32, 1'b0});
    check("sta_written", 32'(dmem[8'h50]), 32'hA5);

    // Reset in the middle of a pending read
    wait_mem(8'h51, "lda_req");
    reset = 1'b0;
    step(1);
    check("reset_mid_mem", {state, dmem_req}, {3'd0, 1'b0});
    // Program B (loaded while reset is held)
    imem[8'h00] = ins(4'hB, 8'h90);  // JZ 90
    imem[8'h01] = ins(4'h1, 8'h62);  // LDA 62
    imem[8'h02] = ins(4'h4, 8'h63);  // SUB 63
    imem[8'h03] = ins(4'h1, 8'h60);  // LDA 60
    imem[8'h04] = ins(4'hE, 8'h61);  // ADC 61 or NOP
    imem[8'h05] = ins(4'h9, 8'h00);  // OUT
    imem[8'h06] = ins(4'h1, 8'h61);  // LDA 61
    imem[8'h07] = ins(4'hA, 8'hFF);  // JMP FF
    imem[8'hFF] = ins(4'h0, 8'h00);  // NOP
    imem[8'h90] = ins(4'hF, 8'h00);  // HLT
    dmem[8'h60] = 8'hFF;
    dmem[8'h61] = 8'h00;
    dmem[8'h62] = 8'h01;
    dmem[8'h63] = 8'h01;
    step(2);
    check("reset_held",
          {state, imem_addr, dmem_req, out_data, out_valid, flags, halted},
          32'd0);
    ack_delay = 0;
    reset     = 1'b1;

    // Opcode E: FF+00+C(1) = 00 (Z,C) with ADC, else NOP leaves FF (N,C)
    wait_out("out_pulse_b");
    check("opcode_e", {out_data, flags},
          ADC_EN ? {8'h00, 4'b0110} : {8'hFF, 4'b1010});

    // PC wrap and HALT
    wait_fetch(8'hFF, "jmp_ff");
    step(2);
    check("pc_wrap", {state, imem_addr}, {3'd0, 8'h00});
    step(2);
    check("jz_to_hlt", {state, imem_addr}, {3'd0, 8'h90});
    step(2);
    check("halted", {state, halted}, {3'd4, 1'b1});
    any_req = 1'b0;
    for (int i = 0; i < 20; i++) begin
      ack_force = ~ack_force;
      step(1);
      any_req = any_req | (dmem_req !== 1'b0);
    end
    ack_force = 1'b0;
    check("halt_no_req", 32'(any_req), 32'd0);
    check("halt_frozen", {state, halted, flags, imem_addr, out_valid},
          {3'd4, 1'b1, 4'b0110, 8'h91, 1'b0});

    // Reset pulse leaves HALT and restarts from PC=0
    reset = 1'b0;
    step(1);
    reset = 1'b1;
    check("halt_reset", {state, halted, flags, imem_addr}, 32'd0);
    step(2);
    check("restart", {state, imem_addr}, {3'd0, 8'h01});

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/acc_core.md
Name: acc_core

Overview:
- Parametrised successor to the 4-bit-address/8-bit accumulator datapath.
- Multi-cycle accumulator CPU core with the control FSM integrated.
- Adds configurable data and address width, a persistent flags register, conditional branches, halt, and a valid/ack data-memory handshake.
- Harvard organisation: combinational instruction port plus handshaked data port. Sits between the program ROM and the data RAM/peripheral fabric.

Parameters:
- DW, 8: data width of AC, B, O, ALU and data bus.
- AW, 8: address width of PC, instruction address field and data address; instruction width IW = 4+AW.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-low reset.
- imem_addr  out  AW  equals PC.
- imem_rdata  in  IW  instruction {opcode[3:0], addr[AW-1:0]}; valid in the same cycle (combinational ROM).
- dmem_req  out  1  data access request.
- dmem_we  out  1  1 = write, 0 = read; qualified by dmem_req.
- dmem_addr  out  AW  data address (IR address field).
- dmem_wdata  out  DW  AC value for writes.
- dmem_rdata  in  DW  read data; sampled on the ack cycle.
- dmem_ack  in  1  access complete.
- out_data  out  DW  O register.
- out_valid  out  1  one-cycle pulse when O is written.
- flags  out  4  registered {N,Z,C,V}.
- halted  out  1  core is stopped in HALT.
- state  out  3  debug: current FSM state.

Behaviour:
- Reset (reset==0 at a clk edge):
  - PC, IR, AC, B, O, flags = 0; out_valid = 0; halted = 0; state = FETCH.
  - Dominates all other activity, including mid-MEM. dmem_req is low from the first post-edge cycle; any in-flight access is abandoned and its later ack is ignored.
- FSM states: FETCH=0, DECODE=1, MEM=2, EXEC=3, HALT=4.
- FETCH: IR <= imem_rdata; PC <= PC+1 mod 2^AW; go to DECODE.
- DECODE, by opcode:
  - 0 NOP: go to FETCH.
  - 1 LDA, 2 STA, 3 ADD, 4 SUB, 5 AND, 6 OR, 7 XOR: go to MEM.
  - 8 NOT: AC <= ~AC; Z and N updated; C = V = 0; go to FETCH.
  - 9 OUT: O <= AC; out_valid = 1 in the following cycle only; go to FETCH.
  - A JMP: PC <= addr.
  - B JZ, C JN, D JC: PC <= addr if Z / N / C is set, otherwise PC is unchanged. For A–D, go to FETCH.
  - E: reserved, see Optional Feature.
  - F HLT: go to HALT.
- MEM:
  - dmem_req = 1 (Moore output of the state register); dmem_addr = IR.addr; dmem_we = (opcode==STA); dmem_wdata = AC.
  - All four signals are held stable until the ack cycle. An ack in the first MEM cycle is legal.
  - On ack: LDA: AC <= rdata, Z/N updated, C/V unchanged, go to FETCH. STA: go to FETCH. ALU ops: B <= rdata, go to EXEC.
  - No ack: remain in MEM indefinitely.
  - dmem_ack outside MEM is ignored.
- EXEC: AC <= ALU(AC, B), all four flags updated; go to FETCH.
- ALU, DW bits, modulo 2^DW:
  - ADD: C = carry out; V = signed overflow.
  - SUB (AC-B): C = no-borrow (AC >= B unsigned); V = signed overflow.
  - AND/OR/XOR: C = V = 0.
  - Z = (result==0); N = result[DW-1].
- Latency in cycles: NOP/NOT/OUT/JMP/Jcc = 2; LDA/STA = 2 + MEM cycles (min 3); ALU ops = 3 + MEM cycles (min 4).
- HALT: halted = 1; no requests; all registers frozen; the only exit is reset.
- Flags change only as listed above; branches, STA, NOP and OUT leave them unchanged.
- PC wraps from 2^AW-1 to 0 with no fault.

Optional Feature:
- Macro: ACC_CORE_ADC_EN.
- Defined: opcode E = ADC, AC <= AC + B + C. It follows the same MEM → EXEC path as ADD, and flags are computed as for ADD including the carry-in.
- Undefined: opcode E behaves exactly as NOP (2 cycles, no state change besides PC).

Test Plan:
- Reset: hold reset=0 for 3 cycles mid-program → all outputs 0, state=0, imem_addr=0x00; first fetch after release at 0x00.
- LDA 0x10 (mem=0x7F), ADD 0x11 (mem=0x01), OUT, with immediate acks → AC=0x80, flags N=1 Z=0 C=0 V=1; out_data=0x80 with out_valid high for exactly one cycle.
- LDA 0x20 (=0x05), SUB 0x21 (=0x05), JN 0x40, JZ 0x30 → Z=1, C=1; JN not taken (PC advances); next imem_addr=0x30.
- STA 0x50 with AC=0xA5 and ack delayed 3 cycles → dmem_req=1, we=1, addr=0x50, wdata=0xA5 stable for all 3 cycles; FETCH is entered in the cycle after ack. Drive reset low while in MEM on another access → req drops after that edge.
- JMP 0xFF, NOP at 0xFF → next imem_addr=0x00 (wrap); opcode E = NOP without the macro, and AC+B+C with ACC_CORE_ADC_EN (0xFF+0x00+1 → AC=0x00, Z=1, C=1).
- HLT → halted=1, no dmem_req for 20 cycles despite toggling dmem_ack, flags frozen; a reset pulse restarts from PC=0.
